// File: rtl/spi_message_receiver.sv
// spi_message_receiver
//   SPI target-side deserializer for 26-bit {address, flag, data} frames.
//   sclk, cs_n and mosi are oversampled in the clock domain. Frames are
//   assembled MSB first. A good frame (flag bit = 1) produces a one-cycle
//   msg_valid with registered address/data. Bad-flag, short and overrun
//   frames produce a one-cycle frame_error.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   sclk         SPI clock (async, idle low)
//   cs_n         SPI chip select (async, active low)
//   mosi         SPI serial data in (async)
//   miso         SPI serial data out (echo of previous good frame, or 0)
//   msg_valid    one-cycle pulse, new good frame latched
//   msg_address  address of last good frame
//   msg_data     data of last good frame
//   frame_error  one-cycle pulse, bad / short / overrun frame
//   msg_count    count of good frames, wraps
//
// Build option
//   SPI_RX_ECHO_EN  when defined, miso shifts out {msg_address, 1, msg_data}
//                   of the previous good frame during the current frame.
//
// State table
//   IDLE  | waiting for a cs_n falling edge
//   SHIFT | collecting frame bits on sclk rising edges
//   HOLD  | frame complete, waiting for cs_n to rise (flags one overrun)

module spi_message_receiver #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   cs_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   msg_valid,
    output logic [ADDR_WIDTH-1:0]  msg_address,
    output logic [DATA_WIDTH-1:0]  msg_data,
    output logic                   frame_error,
    output logic [COUNT_WIDTH-1:0] msg_count
);

    localparam int FRAME_BITS = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Synchronisers: two flops plus a history flop for edge detection.
    // mosi only needs its level, taken at the same stage as sclk_s2_q.
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q,   cs_s2_q,   cs_h_q;
    logic mosi_s1_q, mosi_s2_q;

    state_t                  state_q,   state_d;
    logic [FRAME_BITS-2:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic [COUNT_WIDTH-1:0]  count_q,   count_d;
    logic                    valid_q,   valid_d;
    logic                    err_q,     err_d;
    logic                    overrun_q, overrun_d;
    logic [1:0]              warm_q,    warm_d;

    logic                    sclk_rise;
    logic                    cs_rise;
    logic                    cs_fall;
    logic [FRAME_BITS-1:0]   frame_next;

    assign sclk_rise  = sclk_s2_q & ~sclk_h_q;
    assign cs_rise    = cs_s2_q & ~cs_h_q;
    // The cs_n pipeline resets high; until real samples reach the history
    // flop a low cs_n would look like a falling edge, so mask it.
    assign cs_fall    = ~cs_s2_q & cs_h_q & (warm_q == 2'd0);
    assign frame_next = {shift_q, mosi_s2_q};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        overrun_d = overrun_q;
        warm_d    = (warm_q != 2'd0) ? warm_q - 2'd1 : 2'd0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d   = frame_next[FRAME_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        if (frame_next[DATA_WIDTH]) begin
                            addr_d  = frame_next[FRAME_BITS-1 -: ADDR_WIDTH];
                            data_d  = frame_next[DATA_WIDTH-1:0];
                            valid_d = 1'b1;
                            count_d = count_q + COUNT_WIDTH'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                        overrun_d = 1'b0;
                        state_d   = HOLD;
                    end
                end
                // cs_n rise is evaluated after any sclk rise of the same cycle.
                if (cs_rise) begin
                    if (state_d == SHIFT && bit_cnt_d != '0) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (sclk_rise && !overrun_q) begin
                    err_d     = 1'b1;
                    overrun_d = 1'b1;
                end
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            warm_q    <= 2'd3;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            warm_q    <= warm_d;
        end
    end

    assign msg_valid   = valid_q;
    assign msg_address = addr_q;
    assign msg_data    = data_q;
    assign frame_error = err_q;
    assign msg_count   = count_q;

`ifdef SPI_RX_ECHO_EN
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic                  sclk_fall;

    assign sclk_fall = ~sclk_s2_q & sclk_h_q;

    always_comb begin
        tx_d = tx_q;
        if (state_q == IDLE && cs_fall) begin
            tx_d = {addr_q, 1'b1, data_q};
        end else if (state_q == SHIFT && sclk_fall) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign miso = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_message_receiver.sv
// Directed bench for spi_message_receiver: sclk driven 4 clocks low / 4 high,
// outputs sampled on the falling clock edge.

module tb_spi_message_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        msg_valid;
    logic [8:0]  msg_address;
    logic [15:0] msg_data;
    logic        frame_error;
    logic [7:0]  msg_count;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int n_valid   = 0;
    int n_err     = 0;
    int valid_cyc = -1;
    int err_cyc   = -1;
    int rise_cyc  = 0;
    logic [31:0] miso_cap = '0;

    spi_message_receiver dut (
        .clock       (clock),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .msg_valid   (msg_valid),
        .msg_address (msg_address),
        .msg_data    (msg_data),
        .frame_error (frame_error),
        .msg_count   (msg_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (msg_valid === 1'b1) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (frame_error === 1'b1) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
    end

    task automatic cs_low();
        @(negedge clock);
        cs_n = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clock);
        cs_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic clock_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (4) @(negedge clock);
            sclk     = 1'b1;
            rise_cyc = cyc;
            miso_cap = {miso_cap[30:0], miso};
            repeat (4) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [8:0] a, input logic f, input logic [15:0] d);
        cs_low();
        clock_bits({6'd0, a, f, d}, 26);
        cs_high();
    endtask

    task automatic test_reset();
        total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", msg_valid); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_error); end
        total++; if (msg_address !== 9'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", msg_address); end
        total++; if (msg_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", msg_data); end
        total++; if (msg_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", msg_count); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    endtask

    task automatic test_good_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(9'h0AA, 1'b1, 16'h7E3C);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL good_valid_pulses got=%0d exp=1", n_valid - v0); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL good_err_pulses got=%0d exp=0", n_err - e0); end
        total++; if (valid_cyc - rise_cyc != 3) begin bad++; $display("FAIL good_latency got=%0d exp=3", valid_cyc - rise_cyc); end
        total++; if (msg_address !== 9'h0AA) begin bad++; $display("FAIL good_addr got=%h exp=0aa", msg_address); end
        total++; if (msg_data !== 16'h7E3C) begin bad++; $display("FAIL good_data got=%h exp=7e3c", msg_data); end
        total++; if (msg_count !== 8'd1) begin bad++; $display("FAIL good_count got=%0d exp=1", msg_count); end
    endtask

    task automatic test_flag_error();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(9'h123, 1'b0, 16'hBEEF);
        total++; if (n_err - e0 != 1) begin bad++; $display("FAIL flag_err_pulses got=%0d exp=1", n_err - e0); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL flag_valid_pulses got=%0d exp=0", n_valid - v0); end
        total++; if (msg_address !== 9'h0AA) begin bad++; $display("FAIL flag_addr got=%h exp=0aa", msg_address); end
        total++; if (msg_data !== 16'h7E3C) begin bad++; $display("FAIL flag_data got=%h exp=7e3c", msg_data); end
        total++; if (msg_count !== 8'd1) begin bad++; $display("FAIL flag_count got=%0d exp=1", msg_count); end
    endtask

    task automatic test_short_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        cs_low();
        clock_bits(32'h0000_02B5, 10);
        cs_high();
        total++; if (n_err - e0 != 1) begin bad++; $display("FAIL short_err_pulses got=%0d exp=1", n_err - e0); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL short_valid_pulses got=%0d exp=0", n_valid - v0); end
        total++; if (msg_count !== 8'd1) begin bad++; $display("FAIL short_count got=%0d exp=1", msg_count); end
        v0 = n_valid; e0 = n_err;
        send_frame(9'h155, 1'b1, 16'hE38E);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL after_short_valid got=%0d exp=1", n_valid - v0); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL after_short_err got=%0d exp=0", n_err - e0); end
        total++; if (msg_address !== 9'h155) begin bad++; $display("FAIL after_short_addr got=%h exp=155", msg_address); end
        total++; if (msg_data !== 16'hE38E) begin bad++; $display("FAIL after_short_data got=%h exp=e38e", msg_data); end
        total++; if (msg_count !== 8'd2) begin bad++; $display("FAIL after_short_count got=%0d exp=2", msg_count); end
    endtask

    task automatic test_overrun();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        cs_low();
        clock_bits({4'd0, 9'h0F0, 1'b1, 16'h1234, 2'b11}, 28);
        cs_high();
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL overrun_valid got=%0d exp=1", n_valid - v0); end
        total++; if (n_err - e0 != 1) begin bad++; $display("FAIL overrun_err_pulses got=%0d exp=1", n_err - e0); end
        total++; if (!(err_cyc > valid_cyc)) begin bad++; $display("FAIL overrun_order err_cyc=%0d valid_cyc=%0d exp err after valid", err_cyc, valid_cyc); end
        total++; if (msg_address !== 9'h0F0) begin bad++; $display("FAIL overrun_addr got=%h exp=0f0", msg_address); end
        total++; if (msg_data !== 16'h1234) begin bad++; $display("FAIL overrun_data got=%h exp=1234", msg_data); end
        total++; if (msg_count !== 8'd3) begin bad++; $display("FAIL overrun_count got=%0d exp=3", msg_count); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        logic [31:0] w;
        w = {6'd0, 9'h0AA, 1'b1, 16'h7E3C};
        v0 = n_valid; e0 = n_err;
        cs_low();
        clock_bits(w >> 13, 13);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        clock_bits(w, 13);
        cs_high();
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL midrst_valid got=%0d exp=0", n_valid - v0); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL midrst_err got=%0d exp=0", n_err - e0); end
        total++; if (msg_count !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", msg_count); end
        total++; if (msg_address !== 9'h000) begin bad++; $display("FAIL midrst_addr got=%h exp=000", msg_address); end
        v0 = n_valid;
        send_frame(9'h1C3, 1'b1, 16'h5A5A);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL midrst_next_valid got=%0d exp=1", n_valid - v0); end
        total++; if (msg_count !== 8'd1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", msg_count); end
        total++; if (msg_address !== 9'h1C3) begin bad++; $display("FAIL midrst_next_addr got=%h exp=1c3", msg_address); end
        total++; if (msg_data !== 16'h5A5A) begin bad++; $display("FAIL midrst_next_data got=%h exp=5a5a", msg_data); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        send_frame(9'h001, 1'b1, 16'h0001);
        send_frame(9'h1FF, 1'b1, 16'hFFFF);
        total++; if (n_valid - v0 != 2) begin bad++; $display("FAIL b2b_valid got=%0d exp=2", n_valid - v0); end
        total++; if (msg_address !== 9'h1FF) begin bad++; $display("FAIL b2b_addr got=%h exp=1ff", msg_address); end
        total++; if (msg_data !== 16'hFFFF) begin bad++; $display("FAIL b2b_data got=%h exp=ffff", msg_data); end
        total++; if (msg_count !== 8'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", msg_count); end
    endtask

    task automatic test_echo();
        send_frame(9'h0AA, 1'b1, 16'h7E3C);
        miso_cap = '0;
        send_frame(9'h055, 1'b1, 16'h1111);
`ifdef SPI_RX_ECHO_EN
        total++; if (miso_cap[25:0] !== {9'h0AA, 1'b1, 16'h7E3C}) begin bad++; $display("FAIL echo_bits got=%h exp=%h", miso_cap[25:0], {9'h0AA, 1'b1, 16'h7E3C}); end
`else
        total++; if (miso_cap !== 32'h0) begin bad++; $display("FAIL echo_tied_low got=%h exp=0", miso_cap); end
`endif
        total++; if (msg_count !== 8'd5) begin bad++; $display("FAIL echo_count got=%0d exp=5", msg_count); end
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        test_reset();
        test_good_frame();
        test_flag_error();
        test_short_frame();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_echo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
